// File: rtl/ins_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words and writes instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the instruction bytes.
module ins_loader #(
  parameter int ADDR_W       = 10,
  parameter int MAX_WORDS    = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              WRITE_INSTRUCTION,
  output logic [31:0]       INS,
  output logic [ADDR_W-1:0] ADDR,
  output logic              INS_MEM_RST,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_LEN0, S_LEN1, S_BYTES, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t      state, state_next;
  logic [15:0] clr_cnt;
  logic [15:0] word_cnt;
  logic [15:0] len;
  logic [15:0] len_rx;
  logic [7:0]  len_lo;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic        xfer, len_bad, last_word, recv_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_comb begin
    xfer       = byte_valid && byte_ready;
    len_rx     = {byte_data, len_lo};
    len_bad    = (len_rx == 16'd0) || (len_rx > 16'(MAX_WORDS));
    last_word  = (16'(word_cnt + 16'd1) == len);
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_CLEAR;
      S_CLEAR: if (clr_cnt == 16'(CLEAR_CYCLES - 1)) state_next = S_LEN0;
      S_LEN0:  if (xfer) state_next = S_LEN1;
      S_LEN1:  if (xfer) state_next = len_bad ? S_ERR : S_BYTES;
      S_BYTES: if (xfer && lane == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_BYTES;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK:   if (xfer) state_next = (byte_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase
    recv_next = (state_next == S_LEN0) || (state_next == S_LEN1) || (state_next == S_BYTES);
`ifdef LOADER_CHECKSUM_EN
    if (state_next == S_CHK) recv_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready        <= 1'b0;
      WRITE_INSTRUCTION <= 1'b0;
      INS               <= '0;
      ADDR              <= '0;
      INS_MEM_RST       <= 1'b0;
      cpu_rst           <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      clr_cnt           <= '0;
      word_cnt          <= '0;
      len               <= '0;
      len_lo            <= '0;
      lane              <= '0;
      word_buf          <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum              <= '0;
`endif
    end else begin
      byte_ready        <= recv_next;
      WRITE_INSTRUCTION <= (state_next == S_WRITE);
      INS_MEM_RST       <= (state_next == S_CLEAR);
      cpu_rst           <= (state_next != S_DONE);
      busy              <= !((state_next == S_IDLE) || (state_next == S_DONE) || (state_next == S_ERR));
      done              <= (state_next == S_DONE);
      error             <= (state_next == S_ERR);
      clr_cnt           <= (state == S_CLEAR) ? 16'(clr_cnt + 16'd1) : 16'd0;
      if (state == S_LEN0 && xfer) len_lo <= byte_data;
      if (state == S_LEN1 && xfer) begin
        len      <= len_rx;
        word_cnt <= '0;
        ADDR     <= '0;
        lane     <= '0;
      end
      // Bytes arrive LSB first, so shifting right leaves lane 0 in the low bits.
      if (state == S_BYTES && xfer) begin
        lane     <= lane + 2'd1;
        word_buf <= {byte_data, word_buf[23:8]};
        if (lane == 2'd3) INS <= {byte_data, word_buf};
      end
      if (state == S_WRITE) begin
        ADDR     <= ADDR + ADDR_W'(1);
        word_cnt <= 16'(word_cnt + 16'd1);
        lane     <= '0;
      end
`ifdef LOADER_CHECKSUM_EN
      if (state == S_CLEAR) csum <= '0;
      else if (state == S_BYTES && xfer) csum <= csum ^ byte_data;
`endif
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Directed self-checking bench for ins_loader; checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_ins_loader;
  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, WRITE_INSTRUCTION, INS_MEM_RST, cpu_rst, busy, done, error;
  logic [31:0] INS;
  logic [9:0]  ADDR;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  stim[$];
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_ins[$];
  int          rst_cycles;
  int          wr_ready_hi;

  ins_loader #(.ADDR_W(10), .MAX_WORDS(1024), .CLEAR_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .WRITE_INSTRUCTION(WRITE_INSTRUCTION), .INS(INS), .ADDR(ADDR),
    .INS_MEM_RST(INS_MEM_RST), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Records every write strobe and clear cycle seen between edges.
  always @(negedge clk) begin
    if (WRITE_INSTRUCTION) begin
      wr_addr.push_back(ADDR);
      wr_ins.push_back(INS);
      if (byte_ready) wr_ready_hi++;
    end
    if (INS_MEM_RST) rst_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_ins.delete();
    rst_cycles  = 0;
    wr_ready_hi = 0;
  endtask

  function automatic logic [7:0] stim_xor();
    logic [7:0] x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    return x;
  endfunction

  task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(stim_xor());
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 200) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic applyStimulus(input int gap, input int start_at);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(stim[i], gap);
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("end_timeout", 32'(done || error), 32'd1);
  endtask

  task automatic check_reset(input string p);
    checkOutput({p, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({p, "_done"}, 32'(done), 32'd0);
    checkOutput({p, "_error"}, 32'(error), 32'd0);
    checkOutput({p, "_busy"}, 32'(busy), 32'd0);
    checkOutput({p, "_wr"}, 32'(WRITE_INSTRUCTION), 32'd0);
    checkOutput({p, "_ready"}, 32'(byte_ready), 32'd0);
    checkOutput({p, "_addr"}, 32'(ADDR), 32'd0);
    checkOutput({p, "_ins"}, INS, 32'd0);
  endtask

  task automatic check_two_word(input string p);
    checkOutput({p, "_done"}, 32'(done), 32'd1);
    checkOutput({p, "_error"}, 32'(error), 32'd0);
    checkOutput({p, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    checkOutput({p, "_busy"}, 32'(busy), 32'd0);
    checkOutput({p, "_clear_cycles"}, 32'(rst_cycles), 32'd2);
    checkOutput({p, "_ready_in_write"}, 32'(wr_ready_hi), 32'd0);
    checkOutput({p, "_wr_count"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      checkOutput({p, "_addr0"}, 32'(wr_addr[0]), 32'd0);
      checkOutput({p, "_ins0"}, wr_ins[0], 32'h0050_0013);
      checkOutput({p, "_addr1"}, 32'(wr_addr[1]), 32'd1);
      checkOutput({p, "_ins1"}, wr_ins[1], 32'h0000_0133);
    end
  endtask

  task automatic check_bad_len(input string p);
    checkOutput({p, "_error"}, 32'(error), 32'd1);
    checkOutput({p, "_done"}, 32'(done), 32'd0);
    checkOutput({p, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({p, "_busy"}, 32'(busy), 32'd0);
    checkOutput({p, "_ready"}, 32'(byte_ready), 32'd0);
    checkOutput({p, "_wr_count"}, 32'(wr_addr.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    clear_mon();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h33, 8'h01, 8'h00, 8'h00};
    add_csum();
    clear_mon();
    applyStimulus(0, -1);
    wait_end();
    check_two_word("b2b");

    clear_mon();
    applyStimulus(3, -1);
    wait_end();
    check_two_word("gap");

    stim = '{8'h00, 8'h00};
    clear_mon();
    applyStimulus(0, -1);
    wait_end();
    check_bad_len("len0");

    stim = '{8'h01, 8'h04};
    clear_mon();
    applyStimulus(0, -1);
    wait_end();
    check_bad_len("len1025");

    // Abort a 3-word load right after its first word is assembled.
    stim = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");

    stim = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    add_csum();
    clear_mon();
    applyStimulus(0, 3);
    wait_end();
    checkOutput("reload_done", 32'(done), 32'd1);
    checkOutput("reload_cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("reload_clear_cycles", 32'(rst_cycles), 32'd2);
    checkOutput("reload_wr_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      checkOutput("reload_addr", 32'(wr_addr[0]), 32'd0);
      checkOutput("reload_ins", wr_ins[0], 32'hddcc_bbaa);
    end

`ifdef LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    clear_mon();
    applyStimulus(0, -1);
    wait_end();
    checkOutput("csum_ok_done", 32'(done), 32'd1);
    checkOutput("csum_ok_error", 32'(error), 32'd0);
    checkOutput("csum_ok_cpu_rst", 32'(cpu_rst), 32'd0);

    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    clear_mon();
    applyStimulus(0, -1);
    wait_end();
    checkOutput("csum_bad_error", 32'(error), 32'd1);
    checkOutput("csum_bad_done", 32'(done), 32'd0);
    checkOutput("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("csum_bad_wr_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      checkOutput("csum_bad_addr", 32'(wr_addr[0]), 32'd0);
      checkOutput("csum_bad_ins", wr_ins[0], 32'h4433_2211);
    end
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
- Upstream feeder for the processor top: takes a byte stream (e.g. from a UART receiver), packs bytes into 32-bit instruction words, and drives the processor's instruction-memory write port (WRITE_INSTRUCTION, INS, ADDR, INS_MEM_RST).
- Holds the core in reset while loading.
- Releases the core once the full program is written.

Parameters:
- ADDR_W, 10, instruction-memory address width; must match the processor ADDR port.
- MAX_WORDS, 1024, largest accepted program length in words; must be <= 2**ADDR_W.
- CLEAR_CYCLES, 2, number of cycles INS_MEM_RST is held high at load start; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless the FSM is in IDLE, DONE or ERR.
- byte_valid  in  1  stream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle; a transfer occurs when byte_valid && byte_ready.
- WRITE_INSTRUCTION  out  1  one-cycle write strobe to instruction memory.
- INS  out  32  instruction word being written.
- ADDR  out  ADDR_W  write address.
- INS_MEM_RST  out  1  instruction-memory clear.
- cpu_rst  out  1  reset to the processor core; high = core held.
- busy  out  1  load in progress.
- done  out  1  program loaded and core released.
- error  out  1  load aborted.

Behaviour:
- Reset values:
  - State IDLE.
  - byte_ready, WRITE_INSTRUCTION, INS_MEM_RST, busy, done and error all 0.
  - INS = 0, ADDR = 0.
  - cpu_rst = 1; the core stays held until a load completes.
- All outputs are registered.
- rst asserted in any state, including mid-load, returns to the reset values on the next edge. Partially written memory is left as is.
- Stream format, little-endian:
  - LEN_LO, LEN_HI give the 16-bit word count N.
  - Then 4*N instruction bytes, least significant byte first.
  - With LOADER_CHECKSUM_EN defined, one checksum byte follows.
- States:
  - IDLE: wait for start.
  - CLEAR: on start, set INS_MEM_RST=1, cpu_rst=1, busy=1, and clear done and error. Hold for CLEAR_CYCLES cycles, then go to LEN0.
  - LEN0 / LEN1: byte_ready=1; capture the low and high bytes of N.
    - After LEN1: if N==0 or N>MAX_WORDS, go to ERR. Otherwise set the word counter and ADDR to 0 and go to BYTES.
  - BYTES: byte_ready=1; shift the accepted byte into byte lane k (k = 0..3, lane k = bits 8k+7:8k).
    - After lane 3 is accepted, go to WRITE.
  - WRITE: byte_ready=0; INS holds the assembled word and WRITE_INSTRUCTION=1 for exactly this one cycle with ADDR = word index.
    - Next cycle: ADDR increments and the lane index resets to 0.
    - If the word count reaches N, go to CHK (feature on) or DONE (feature off); otherwise back to BYTES.
  - DONE: cpu_rst=0, done=1, busy=0.
  - ERR: error=1, busy=0, cpu_rst=1, byte_ready=0.
  - DONE and ERR persist until the next start or rst.
- Throughput:
  - At most one byte per cycle in BYTES.
  - Each word costs at least 5 cycles (4 bytes + 1 WRITE).
  - Latency from the 4th byte handshake to the write strobe is exactly 1 cycle.
- byte_valid gaps are tolerated in any receiving state; no timeout.
- start asserted while busy=1 is ignored.
- start in DONE re-enters CLEAR with cpu_rst=1 on the next edge.
- ADDR never exceeds MAX_WORDS-1 during a write; it wraps only via a new load.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - A running 8-bit XOR is kept over all 4*N instruction bytes; LEN bytes are excluded.
  - State CHK accepts one extra byte (byte_ready=1).
  - If it equals the running XOR, go to DONE; otherwise go to ERR with the core kept in reset. Words already written are not erased.
- Undefined: no CHK state and no XOR logic; DONE follows the last WRITE directly.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles -> cpu_rst=1, done=0, error=0, WRITE_INSTRUCTION=0, ADDR=0.
- Two-word load, bytes sent back to back:
  - Stream: start, 02 00, 13 00 50 00, 33 01 00 00.
  - Response: INS_MEM_RST high for 2 cycles; write strobes at ADDR 0 with INS=0x00500013 and at ADDR 1 with INS=0x00000133; then done=1, cpu_rst=0.
- Same load with byte_valid low for 3 cycles between every byte -> identical writes and data; byte_ready=0 during each WRITE cycle.
- Bad length: LEN=00 00 -> ERR (error=1, cpu_rst=1, no strobe). LEN=01 04 (1025) -> same result.
- Reset mid-operation and start while busy:
  - rst asserted after the 6th byte of a 3-word load -> all outputs return to reset values.
  - A following full 1-word load writes ADDR 0 correctly.
  - A start pulse issued during the load changes nothing.
- With LOADER_CHECKSUM_EN:
  - 1-word load of bytes 11 22 33 44 with checksum byte 0x44 -> DONE.
  - Checksum byte 0x45 -> ERR after the write at ADDR 0, cpu_rst stays 1.
